// File: rtl/deinterleaver.sv
// WiMAX receive bit deinterleaver: ping-pong block buffer writing bits at the
// inverse-permuted address and reading them out in FEC order.
// Optional completed-block counter port: define DEINT_BLK_CNT_EN.
module deinterleaver #(
  parameter int NCBPS = 192,
  parameter int NCPC  = 2,
  parameter int D     = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        data_in,
  input  logic        valid_demod,
  output logic        ready_deinterleaver,
  output logic        data_out,
  output logic        valid_deinterleaver,
  input  logic        ready_fec_dec
`ifdef DEINT_BLK_CNT_EN
  ,
  output logic [15:0] blk_count
`endif
);
  localparam int S  = ((NCPC + 1) / 2 < 1) ? 1 : (NCPC + 1) / 2;
  localparam int AW = $clog2(NCBPS);
  localparam int MW = $clog2(D * NCBPS) + 1;
  localparam logic [MW-1:0] S_C  = MW'(S);
  localparam logic [MW-1:0] D_C  = MW'(D);
  localparam logic [MW-1:0] N_C  = MW'(NCBPS);
  localparam logic [MW-1:0] N1_C = MW'(NCBPS - 1);
  localparam logic [AW-1:0] LAST = AW'(NCBPS - 1);

  logic [AW-1:0]    j_q, j_d, k_q, k_d, wr_addr;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [NCBPS-1:0] bank_q [2];
  logic [MW-1:0]    jx, m, dm;
  logic             wr_fire, rd_fire;

  assign ready_deinterleaver = !full_q[wr_bank_q];
  assign valid_deinterleaver = full_q[rd_bank_q];
  assign data_out            = bank_q[rd_bank_q][k_q];
  assign wr_fire             = valid_demod && ready_deinterleaver;
  assign rd_fire             = valid_deinterleaver && ready_fec_dec;

  // Inverse of both permutation steps; sized so d*(Ncbps-1) never overflows.
  always_comb begin
    jx      = MW'(j_q);
    m       = S_C * (jx / S_C) + ((jx + (D_C * jx) / N_C) % S_C);
    dm      = D_C * m;
    wr_addr = AW'(dm - N1_C * (dm / N_C));
  end

  always_comb begin
    j_d       = j_q;
    k_d       = k_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (wr_fire) begin
      if (j_q == LAST) begin
        j_d               = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        j_d = j_q + AW'(1);
      end
    end
    // A finishing write and a finishing read always target different banks.
    if (rd_fire) begin
      if (k_q == LAST) begin
        k_d               = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        k_d = k_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      j_q       <= '0;
      k_q       <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      j_q       <= j_d;
      k_q       <= k_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN && wr_fire) bank_q[wr_bank_q][wr_addr] <= data_in;
  end

`ifdef DEINT_BLK_CNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetN) blk_cnt_q <= '0;
    else if (rd_fire && k_q == LAST) blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// Scoreboard bench for deinterleaver: expected FEC-order bits are queued as
// each block is driven and popped as the DUT hands bits to the decoder.
module tb_deinterleaver;
  localparam int N = 192;
  localparam int S = 1;
  localparam int D = 16;

  logic clk = 1'b0;
  logic resetN, data_in, valid_demod, ready_fec_dec;
  logic ready_deinterleaver, data_out, valid_deinterleaver;
`ifdef DEINT_BLK_CNT_EN
  logic [15:0] blk_count;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_stall = 0;
  logic sb_q[$];

  always #5 clk = ~clk;

  deinterleaver dut (
    .clk                (clk),
    .resetN             (resetN),
    .data_in            (data_in),
    .valid_demod        (valid_demod),
    .ready_deinterleaver(ready_deinterleaver),
    .data_out           (data_out),
    .valid_deinterleaver(valid_deinterleaver),
    .ready_fec_dec      (ready_fec_dec)
`ifdef DEINT_BLK_CNT_EN
    ,
    .blk_count          (blk_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Transmit-side address for input index j of the on-air stream.
  function automatic int kk_of(input int j);
    int m;
    m = S * (j / S) + ((j + (D * j) / N) % S);
    return D * m - (N - 1) * ((D * m) / N);
  endfunction

  function automatic logic [N-1:0] tx_of(input logic [N-1:0] orig);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = orig[kk_of(j)];
    return r;
  endfunction

  always @(negedge clk) begin
    if (resetN && valid_deinterleaver && ready_fec_dec) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("data", {31'd0, data_out}, {31'd0, sb_q.pop_front()});
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic put_bit(input logic b);
    logic acc;
    int   t = 0;
    data_in     = b;
    valid_demod = 1'b1;
    forever begin
      @(negedge clk);
      acc = ready_deinterleaver;
      @(posedge clk);
      #1;
      if (acc) break;
      n_stall++;
      if (++t > 2000) begin
        chk("in_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_block(input logic [N-1:0] inbits, input logic [N-1:0] expbits,
                            input int nbits, input bit push, input bit lat);
    if (push) for (int i = 0; i < N; i++) sb_q.push_back(expbits[i]);
    for (int j = 0; j < nbits; j++) begin
      if (lat && j == N - 1) chk("lat_pre", {31'd0, valid_deinterleaver}, 32'd0);
      put_bit(inbits[j]);
    end
    if (lat) chk("lat_post", {31'd0, valid_deinterleaver}, 32'd1);
    valid_demod = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || valid_deinterleaver) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    if (t >= 3000) chk("drain_timeout", t, 0);
  endtask

  initial begin
    logic [N-1:0] o, a, b;
    logic         h;
    int           st0;
`ifdef DEINT_BLK_CNT_EN
    logic [15:0]  bc0;
`endif
    resetN = 1'b0; data_in = 1'b0; valid_demod = 1'b0; ready_fec_dec = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_deinterleaver}, 32'd1);
    chk("rst_valid", {31'd0, valid_deinterleaver}, 32'd0);
`ifdef DEINT_BLK_CNT_EN
    chk("rst_blk", {16'd0, blk_count}, 32'd0);
`endif
    resetN = 1'b1;

    // Round trip of alternating pattern, with first-output latency.
    for (int i = 0; i < N; i++) o[i] = 1'(i % 2);
    send_block(tx_of(o), o, N, 1'b1, 1'b1);
    drain();

    // Single-hot mapping, stated directly: j=1 -> 16, j=12 -> 1.
    a = '0; a[1] = 1'b1; b = '0; b[16] = 1'b1;
    send_block(a, b, N, 1'b1, 1'b0);
    a = '0; a[12] = 1'b1; b = '0; b[1] = 1'b1;
    send_block(a, b, N, 1'b1, 1'b0);
    drain();

    // Backpressure: both banks fill, output holds, space returns after drain.
    ready_fec_dec = 1'b0;
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < N; i++) o[i] = 1'($urandom_range(0, 1));
      send_block(tx_of(o), o, N, 1'b1, 1'b0);
    end
    chk("bp_rdy_low", {31'd0, ready_deinterleaver}, 32'd0);
    chk("bp_valid", {31'd0, valid_deinterleaver}, 32'd1);
    h = data_out;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_hold", {31'd0, data_out}, {31'd0, h});
    chk("bp_hold_exp", {31'd0, data_out}, {31'd0, sb_q[0]});
    ready_fec_dec = 1'b1;
    repeat (191) @(posedge clk);
    #1;
    chk("bp_rdy_191", {31'd0, ready_deinterleaver}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_rdy_192", {31'd0, ready_deinterleaver}, 32'd1);
    drain();

    // Continuous ping-pong: no input stall once the first block is in.
`ifdef DEINT_BLK_CNT_EN
    bc0 = blk_count;
`endif
    for (int blk = 0; blk < 4; blk++) begin
      if (blk == 1) st0 = n_stall;
      for (int i = 0; i < N; i++) o[i] = 1'($urandom_range(0, 1));
      send_block(tx_of(o), o, N, 1'b1, 1'b0);
    end
    chk("pp_stalls", n_stall - st0, 0);
    drain();
`ifdef DEINT_BLK_CNT_EN
    chk("pp_blk", {16'd0, blk_count - bc0}, 32'd4);
`endif

    // Reset mid-operation, then a fresh block from j=0.
    ready_fec_dec = 1'b0;
    for (int i = 0; i < N; i++) o[i] = 1'($urandom_range(0, 1));
    send_block(tx_of(o), o, N, 1'b1, 1'b0);
    send_block(tx_of(~o), ~o, 100, 1'b0, 1'b0);
    ready_fec_dec = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    resetN = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, valid_deinterleaver}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_deinterleaver}, 32'd1);
`ifdef DEINT_BLK_CNT_EN
    chk("mid_rst_blk", {16'd0, blk_count}, 32'd0);
`endif
    sb_q.delete();
    resetN = 1'b1;
    for (int i = 0; i < N; i++) o[i] = 1'($urandom_range(0, 1));
    send_block(tx_of(o), o, N, 1'b1, 1'b1);
    drain();
    chk("sb_left", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/deinterleaver.md
Name: deinterleaver

Overview:
- Receive-side counterpart of the transmit bit interleaver in the WiMAX PHY chain.
- Accepts one coded bit per handshake from the demapper, in interleaved (on-air) order.
- Undoes the 802.16 two-step permutation over one block of Ncbps bits and streams the bits out serially in original FEC order to the FEC decoder.
- Ping-pong block buffering lets one block fill while the previous block drains.

Parameters:
- Ncbps, 192, coded bits per block; one interleaver block.
- Ncpc, 2, coded bits per carrier (2 = QPSK).
- s, Ncpc/2, permutation granularity; ceiling of Ncpc/2, minimum 1.
- d, 16, interleaver column count.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetN  input  1  synchronous, active-low reset.
- data_in  input  1  received coded bit, interleaved order.
- valid_demod  input  1  data_in valid, from the demapper.
- ready_deinterleaver  output  1  block can accept data_in this cycle.
- data_out  output  1  de-interleaved bit, original order.
- valid_deinterleaver  output  1  data_out valid.
- ready_fec_dec  input  1  FEC decoder accepts data_out this cycle.
- blk_count  output  16  completed-block counter; present only with DEINT_BLK_CNT_EN.

Behaviour:
- Storage: two banks, bank[0..1], each Ncbps bits. Per-bank full flag. Write pointer wr_bank with input index j (0..Ncbps-1). Read pointer rd_bank with output index k (0..Ncbps-1).
- Input accept: a beat is accepted when valid_demod && ready_deinterleaver.
- Address mapping for input index j, integer arithmetic, floor division:
  - m = s*(j/s) + ((j + (d*j)/Ncbps) % s)
  - kk = d*m - (Ncbps-1)*((d*m)/Ncbps)
  - Intermediates sized for d*(Ncbps-1) with no overflow; for the defaults that is at least 12 bits.
- On accept: bank[wr_bank][kk] <= data_in. Then:
  - if j == Ncbps-1: j <= 0, full[wr_bank] <= 1, wr_bank toggles;
  - else j <= j+1.
- ready_deinterleaver = !full[wr_bank], combinational. It is low only when both banks are full.
- Output side, combinational from registers: valid_deinterleaver = full[rd_bank]; data_out = bank[rd_bank][k].
- Output transfer: occurs when valid_deinterleaver && ready_fec_dec. Then:
  - if k == Ncbps-1: k <= 0, full[rd_bank] <= 0, rd_bank toggles;
  - else k <= k+1.
- While valid_deinterleaver is high, data_out is held stable until it is accepted.
- Latency: the first output bit of a block is valid the cycle after the edge that accepted input j = Ncbps-1. Sustained throughput is 1 bit/clk each side.
- Simultaneous events:
  - A write completing one bank and a read draining the other bank in the same cycle both take effect.
  - A bank freed by a read this cycle is writable from the next cycle; there is no same-cycle bypass.
- Permutation check: for Ncpc=2, j=1 maps to kk=16 and j=12 maps to kk=1. This is the exact inverse of the transmit interleaver.
- Reset (resetN low at a clock edge):
  - j, k, wr_bank, rd_bank, full[1:0] go to 0; blk_count goes to 0.
  - Outputs after reset: ready_deinterleaver=1, valid_deinterleaver=0. data_out is don't-care while invalid.
  - Bank contents are not reset.
  - Reset mid-block discards any partially written or partially read block. The first post-reset input is treated as j=0.
- Input while not ready: valid_demod high with ready_deinterleaver low has no effect; the source must hold data_in.

Optional Feature:
- Macro: DEINT_BLK_CNT_EN.
- Defined:
  - Port blk_count[15:0] exists.
  - It increments by 1 on each edge where a block finishes draining (output transfer with k == Ncbps-1).
  - It wraps from 0xFFFF to 0x0000 and resets to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: resetN=0 for 2 cycles -> ready_deinterleaver=1, valid_deinterleaver=0; with the feature on, blk_count=0.
- Round-trip: feed the transmit interleaver output of pattern k[i] = i%2 (192 bits, valid every cycle, ready_fec_dec=1) -> output sequence is 0,1,0,1,... for 192 bits; first valid 1 cycle after input bit 191 is accepted.
- Single-hot mapping: input bit j=1 =1, all others 0 -> output bit index 16 =1, all others 0. Repeat with j=12 -> output index 1 =1.
- Backpressure: ready_fec_dec=0; stream 2 blocks (384 bits) -> ready_deinterleaver drops the cycle after the 384th accept. Raise ready_fec_dec -> ready_deinterleaver returns 1 cycle after the 192nd output; data_out holds while stalled.
- Continuous ping-pong: 4 back-to-back blocks with random data and ready_fec_dec=1 -> no input stall after the first block; outputs match the reference inverse permutation; blk_count=4.
- Reset mid-operation: assert resetN=0 after 100 input bits and 50 output bits -> valid_deinterleaver=0 next cycle. A fresh full block then decodes correctly from j=0.
